// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and the core's decoder.
// Opcode and funct values follow the MIPS-I encoding of the supported subset.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_ORI  = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_LUI  = 4'd10
  } op_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_EMIT,
    ST_FULL
  } enc_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

endpackage

// File: rtl/instr_encoder_if.sv
// Tuple handshake plus instruction-memory write bus of the encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, op_sel, rs, rt, rd, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: op_sel and register/immediate fields -> 32-bit MIPS word.
// legal is low for op_sel codes outside the supported subset.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'b0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] src);
    return {opc, src, rt, imm};
  endfunction

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_sel)
      OP_ADD:  word = rtype(FUNCT_ADD);
      OP_SUB:  word = rtype(FUNCT_SUB);
      OP_AND:  word = rtype(FUNCT_AND);
      OP_OR:   word = rtype(FUNCT_OR);
      OP_ADDI: word = itype(OPC_ADDI, rs);
      OP_ORI:  word = itype(OPC_ORI, rs);
      OP_LW:   word = itype(OPC_LW, rs);
      OP_SW:   word = itype(OPC_SW, rs);
      OP_BEQ:  word = itype(OPC_BEQ, rs);
      OP_BNE:  word = itype(OPC_BNE, rs);
      // lui has no source register; the field must read as zero
      OP_LUI:  word = itype(OPC_LUI, 5'd0);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts op/field tuples and writes the encoded words to
// consecutive instruction-memory addresses, one word every two cycles.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            finish,
  instr_encoder_if.slave  bus,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  enc_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word_p0;
  logic              legal_p0;

  instr_pack u_pack (
    .op_sel (bus.op_sel),
    .rs     (bus.rs),
    .rt     (bus.rt),
    .rd     (bus.rd),
    .imm    (bus.imm),
    .word   (word_p0),
    .legal  (legal_p0)
  );

  // p0 -> p1: the encoded word is captured straight into the write bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= BASE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      count         <= '0;
      full          <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FULL: begin
          if (start) begin
            state        <= ST_ACCEPT;
            bus.in_ready <= 1'b1;
            ptr          <= BASE;
            count        <= '0;
            err          <= 1'b0;
            full         <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          // a pending tuple takes priority over finish
          if (bus.in_valid) begin
            if (legal_p0) begin
              state         <= ST_EMIT;
              bus.in_ready  <= 1'b0;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= ptr;
              bus.mem_wdata <= word_p0;
            end else begin
              err <= 1'b1;
            end
          end else if (finish) begin
            state        <= ST_IDLE;
            bus.in_ready <= 1'b0;
          end
        end
        ST_EMIT: begin
          bus.mem_we <= 1'b0;
          count      <= count + 1'b1;
          // the last address is terminal; ptr never wraps back into the program
          if (ptr == LAST) begin
            state <= ST_FULL;
            full  <= 1'b1;
          end else begin
            ptr          <= ptr + 1'b1;
            state        <= ST_ACCEPT;
            bus.in_ready <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an ADDR_W=8 instance for encoding and
// session control, an ADDR_W=2 instance for address exhaustion.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic finish = 1'b0;
  logic [8:0] count_a;
  logic [2:0] count_b;
  logic full_a, full_b, err_a, err_b;

  int tests = 0;
  int fails = 0;

  instr_encoder_if #(.ADDR_W(8)) bus_a ();
  instr_encoder_if #(.ADDR_W(2)) bus_b ();

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .finish(finish),
    .bus(bus_a), .count(count_a), .full(full_a), .err(err_a)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .finish(finish),
    .bus(bus_b), .count(count_b), .full(full_b), .err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [15:0] im);
    bus_a.op_sel = op; bus_a.rs = s; bus_a.rt = t; bus_a.rd = d; bus_a.imm = im;
    bus_b.op_sel = op; bus_b.rs = s; bus_b.rt = t; bus_b.rd = d; bus_b.imm = im;
  endtask

  // Offers one tuple, waits (bounded) for the handshake edge and returns at the
  // falling edge right after it, where mem_we of the write should be visible.
  task automatic send(input bit to_b, input logic [3:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
                      input logic fin);
    int n;
    @(negedge clk);
    set_fields(op, s, t, d, im);
    finish = fin;
    if (to_b) bus_b.in_valid = 1'b1; else bus_a.in_valid = 1'b1;
    n = 0;
    while (!(to_b ? bus_b.in_ready : bus_a.in_ready) && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait_in_budget", 32'(n < 16), 32'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    finish = 1'b0;
  endtask

  // Checks the write pulse of a word just handed over to dut_a.
  task automatic expect_write_a(input string tag, input logic [7:0] addr, input logic [31:0] w);
    check({tag, "_we"}, 32'(bus_a.mem_we), 32'd1);
    check({tag, "_addr"}, 32'(bus_a.mem_addr), 32'(addr));
    check({tag, "_wdata"}, bus_a.mem_wdata, w);
    @(negedge clk);
    check({tag, "_we_drop"}, 32'(bus_a.mem_we), 32'd0);
    check({tag, "_count"}, 32'(count_a), 32'(addr) + 32'd1);
  endtask

  task automatic pulse_start(input bit to_b);
    @(negedge clk);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int we_seen;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 16'd0);

    // reset state
    #12;
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    check("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus_a.in_ready), 32'd0);

    // first session: a single add, imm must be ignored
    pulse_start(1'b0);
    check("accept_in_ready", 32'(bus_a.in_ready), 32'd1);
    send(1'b0, OP_ADD, 5'd1, 5'd2, 5'd3, 16'hFFFF, 1'b0);
    expect_write_a("add", 8'd0, 32'h0022_1820);
    check("accept_again", 32'(bus_a.in_ready), 32'd1);

    // finish with no tuple returns to IDLE
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("finish_idle", 32'(bus_a.in_ready), 32'd0);

    // second session restarts at address 0
    pulse_start(1'b0);
    check("restart_count", 32'(count_a), 32'd0);
    send(1'b0, OP_ADDI, 5'd0, 5'd8, 5'd31, 16'h0005, 1'b0);
    expect_write_a("addi", 8'd0, 32'h2008_0005);
    send(1'b0, OP_LW, 5'd29, 5'd9, 5'd0, 16'h0004, 1'b0);
    expect_write_a("lw", 8'd1, 32'h8FA9_0004);
    send(1'b0, OP_LUI, 5'd7, 5'd1, 5'd0, 16'h1234, 1'b0);
    expect_write_a("lui", 8'd2, 32'h3C01_1234);
    // finish alongside a valid tuple is ignored
    send(1'b0, OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b1);
    expect_write_a("beq", 8'd3, 32'h1022_FFFF);
    check("finish_ignored", 32'(bus_a.in_ready), 32'd1);
    send(1'b0, OP_SUB, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b0);
    expect_write_a("sub", 8'd4, 32'h0085_3022);
    send(1'b0, OP_AND, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b0);
    expect_write_a("and", 8'd5, 32'h0021_0824);
    send(1'b0, OP_OR, 5'd31, 5'd31, 5'd31, 16'h0000, 1'b0);
    expect_write_a("or", 8'd6, 32'h03FF_F825);
    send(1'b0, OP_ORI, 5'd2, 5'd3, 5'd0, 16'h00FF, 1'b0);
    expect_write_a("ori", 8'd7, 32'h3443_00FF);
    send(1'b0, OP_SW, 5'd29, 5'd31, 5'd0, 16'h0008, 1'b0);
    expect_write_a("sw", 8'd8, 32'hAFBF_0008);
    send(1'b0, OP_BNE, 5'd3, 5'd0, 5'd0, 16'h0002, 1'b0);
    expect_write_a("bne", 8'd9, 32'h1460_0002);

    // start during ACCEPT is ignored
    pulse_start(1'b0);
    check("start_ignored_count", 32'(count_a), 32'd10);

    // illegal op: dropped, err set, nothing written
    send(1'b0, 4'd12, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
    check("illegal_no_we", 32'(bus_a.mem_we), 32'd0);
    check("illegal_err", 32'(err_a), 32'd1);
    @(negedge clk);
    check("illegal_count", 32'(count_a), 32'd10);
    check("illegal_in_ready", 32'(bus_a.in_ready), 32'd1);
    send(1'b0, OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
    expect_write_a("after_illegal", 8'd10, 32'h0022_1820);
    check("err_sticky", 32'(err_a), 32'd1);

    // a new session clears err
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    pulse_start(1'b0);
    check("start_clears_err", 32'(err_a), 32'd0);

    // reset in the middle of EMIT
    send(1'b0, OP_ORI, 5'd1, 5'd1, 5'd0, 16'hABCD, 1'b0);
    check("pre_reset_we", 32'(bus_a.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_we", 32'(bus_a.mem_we), 32'd0);
    check("midreset_addr", 32'(bus_a.mem_addr), 32'd0);
    check("midreset_wdata", bus_a.mem_wdata, 32'd0);
    check("midreset_count", 32'(count_a), 32'd0);
    check("midreset_in_ready", 32'(bus_a.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("postreset_idle", 32'(bus_a.in_ready), 32'd0);
    check("postreset_no_we", 32'(bus_a.mem_we), 32'd0);

    // ADDR_W=2 instance: four writes exhaust the space
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, OP_ADD, 5'(i), 5'd2, 5'd3, 16'h0000, 1'b0);
      check("b_we", 32'(bus_b.mem_we), 32'd1);
      check("b_addr", 32'(bus_b.mem_addr), 32'(i));
    end
    @(negedge clk);
    check("b_full", 32'(full_b), 32'd1);
    check("b_full_in_ready", 32'(bus_b.in_ready), 32'd0);
    check("b_full_count", 32'(count_b), 32'd4);
    // the remaining two tuples are offered but must not be consumed
    bus_b.in_valid = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_b.mem_we) we_seen++;
    end
    bus_b.in_valid = 1'b0;
    check("b_no_write_when_full", 32'(we_seen), 32'd0);
    check("b_count_held", 32'(count_b), 32'd4);

    pulse_start(1'b1);
    check("b_restart_full", 32'(full_b), 32'd0);
    check("b_restart_in_ready", 32'(bus_b.in_ready), 32'd1);
    send(1'b1, OP_SUB, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b0);
    check("b_restart_addr", 32'(bus_b.mem_addr), 32'd0);
    check("b_restart_wdata", bus_b.mem_wdata, 32'h0085_3022);
    @(negedge clk);
    check("b_restart_count", 32'(count_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's instruction decoder: accepts operation and field tuples over a valid/ready handshake and packs them into 32-bit MIPS words.
- Writes each word to successive instruction-memory addresses.
- Used by the bench/boot path to load programs into instruction memory before the core runs.
- Supports the same instruction subset the decoder recognises: add, sub, and, or, addi, ori, lw, sw, beq, bne, lui.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after each start.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin or restart a load session.
- finish  in  1  end the load session.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  encoder can accept a tuple.
- op_sel  in  4  operation select: 0 add, 1 sub, 2 and, 3 or, 4 addi, 5 ori, 6 lw, 7 sw, 8 beq, 9 bne, 10 lui; 11-15 illegal.
- rs  in  5  source register.
- rt  in  5  target register.
- rd  in  5  destination register (R-type only).
- imm  in  16  immediate or branch offset (I-type only).
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written this session.
- full  out  1  address space exhausted.
- err  out  1  sticky: an illegal op_sel was offered.

Behaviour:
- Reset (rst_n=0, async):
  - state IDLE, ptr=BASE_ADDR.
  - in_ready, mem_we, mem_addr, mem_wdata, count, full and err all 0.
- IDLE:
  - in_ready=0.
  - start=1 -> ptr=BASE_ADDR, count=0, err=0; next state ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready with legal op_sel: register the encoded word; next state EMIT.
  - On in_valid&in_ready with illegal op_sel: set err, drop the tuple, stay in ACCEPT; ptr and count unchanged.
  - finish=1 with in_valid=0 -> IDLE.
  - When in_valid=1, finish is ignored that cycle.
- EMIT:
  - in_ready=0; mem_we=1 for exactly one cycle, with mem_addr=ptr and mem_wdata=registered word.
  - Then ptr+1 and count+1.
  - If ptr was 2^ADDR_W-1: next state FULL, no address wrap. Otherwise: next state ACCEPT.
- FULL:
  - in_ready=0, full=1.
  - start -> same restart action as from IDLE; full clears.
- Timing:
  - start is ignored in ACCEPT and EMIT.
  - Latency from handshake to mem_we is 1 cycle.
  - Throughput is 1 word per 2 cycles.
  - mem_addr and mem_wdata hold their last values when mem_we=0.
- R-type encoding:
  - {6'h00, rs, rt, rd, 5'b0, funct}.
  - funct: add 0x20, sub 0x22, and 0x24, or 0x25.
  - imm is ignored.
- I-type encoding:
  - {opcode, rs, rt, imm}.
  - opcode: addi 0x08, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, lui 0x0F.
  - rd is ignored.
  - For lui, the rs field is forced to 0.
- Stability: an in_valid held high while in_ready=0 must not be consumed. The upstream must hold the tuple stable until accepted.
- Reset asserted mid-EMIT aborts the write; mem_we drops immediately.

Decomposition:
- Shared package:
  - op_sel enum.
  - OPC_RTYPE, OPC_ADDI, OPC_ORI, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE, OPC_LUI constants.
  - FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR constants.
  - The decoder reuses the same opcode and funct constants.
- Sub-module instr_pack: combinational op_sel + fields -> {word, legal}. The top holds the FSM, pointer, count and flags.

Test Plan:
- Reset, start, then add with rs=1 rt=2 rd=3 -> one mem_we at addr 0, wdata 0x00221820, count=1.
- addi rs=0 rt=8 imm=5, then lw rs=29 rt=9 imm=4 -> addr 0 gets 0x20080005, addr 1 gets 0x8FA90004, each with a single-cycle mem_we.
- lui rs=7 rt=1 imm=0x1234 -> 0x3C011234 (rs forced 0); beq rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
- op_sel=12 offered -> err=1, no mem_we, count unchanged; a following legal op writes at the same ptr.
- ADDR_W=2, six tuples offered -> four writes at addrs 0-3, then full=1 and in_ready=0. A subsequent start clears full and restarts at 0.
- rst_n pulled low during EMIT -> mem_we drops asynchronously, all outputs read 0, FSM returns to IDLE.
